instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
//
// PURPOSE
//   Instruction fetch stage downstream of the UART instruction loader. Reads
//   32-bit words from port B of instr_mem, which has a 1-cycle synchronous
//   read. Only fetches words the loader has already written (word_count).
//   Presents {instr, instr_pc} to decode over a valid/ready handshake. Supports
//   run/stop control and PC redirect (branch/jump) with flush.
//
// PARAMETERS
//   ADDR_W    8      word-address width of instr_mem (2**ADDR_W words)
//   RESET_PC  32'h0  byte PC loaded at reset; bits [1:0] must be 0
//
// PORTS
//   clk             in   1         system clock, all logic on posedge
//   rst_n           in   1         asynchronous active-low reset
//   run             in   1         1 = fetch enabled; 0 = stop issuing and drain
//   word_count      in   ADDR_W+1  number of valid words loaded (0..2**ADDR_W)
//   mem_addr        out  ADDR_W    instr_mem addr_b = fetch_pc[ADDR_W+1:2]
//   mem_rdata       in   32        instr_mem dout_b, valid 1 cycle after address
//   redirect_valid  in   1         1-cycle pulse: load new PC and flush
//   redirect_pc     in   32        new byte PC; bits [1:0] ignored (forced 0)
//   instr_valid     out  1         instr/instr_pc hold a valid fetched word
//   instr_ready     in   1         decode accepts; transfer = valid & ready
//   instr           out  32        fetched instruction
//   instr_pc        out  32        byte address of instr
//   busy            out  1         1 whenever state==RUN or words pending
//
// BEHAVIOUR
//   - Reset (async, rst_n=0):
//     - state=IDLE; fetch_pc=RESET_PC; buffer empty; in-flight=0.
//     - instr_valid=0, instr=0, instr_pc=0, busy=0, mem_addr=RESET_PC[ADDR_W+1:2].
//     - Reset mid-operation discards all buffered and in-flight words.
//   - FSM:
//     - IDLE -> RUN when run=1 (sampled at posedge; no issue in that cycle).
//     - RUN -> DRAIN when run=0.
//     - DRAIN -> IDLE when buffer empty and in-flight=0.
//     - DRAIN -> RUN if run returns to 1.
//   - Issue condition (combinational, in the current cycle):
//     - state==RUN, fetch_pc[31:2] < word_count, and occ = buf_count + inflight
//       satisfies occ<2, or occ==2 with a transfer this cycle.
//     - On issue: mem_addr=fetch_pc index; fetch_pc += 4; the PC is tagged into
//       an in-flight register.
//   - Return path:
//     - The word on mem_rdata one cycle after issue is pushed, with its PC,
//       into a 2-entry FIFO.
//     - instr_valid rises the cycle after the push: issue at N -> valid at N+2.
//     - Outputs come from the FIFO head, stay stable while valid & !ready, and
//       are held at their last value when the FIFO is empty.
//     - With ready held high and data available: 1 instruction per clock.
//   - Limit: fetch_pc[31:2] >= word_count -> stall with no issue, and resume
//     automatically when word_count grows. fetch_pc never aliases past
//     2**ADDR_W words.
//   - Redirect:
//     - The redirect_valid cycle takes priority over issue.
//     - fetch_pc <= {redirect_pc[31:2],2'b0}. FIFO cleared; in-flight word
//       dropped when it returns.
//     - instr_valid=0 on the next cycle.
//     - A transfer in the redirect cycle itself still counts as delivered.
//     - Redirect in IDLE/DRAIN only updates fetch_pc and does not start fetch.
//   - busy = (state!=IDLE).
//
// TESTING
//   - Reset: rst_n=0 mid-stream with FIFO full -> next cycle instr_valid=0,
//     busy=0, mem_addr=0; after release no fetch until run=1.
//   - Streaming: word_count=4, mem words 0..3 = 0x00000013 + i*0x100, run=1,
//     ready=1 -> 4 transfers on consecutive cycles, pc 0,4,8,C; first valid
//     2 cycles after first issue; then stall, busy stays 1.
//   - Backpressure: ready=0 for 5 cycles during stream -> instr/instr_pc frozen,
//     exactly 2 words buffered, no lost or duplicated PC on release.
//   - Redirect: redirect_valid with redirect_pc=0x0000000E while word at pc 8 is
//     in flight -> pc 8 never delivered; next delivered instr_pc=0x0C.
//   - Limit growth: word_count=0, run=1 -> no issue for 10 cycles; raise to 1 ->
//     instr_pc=0 delivered; full memory (256), pc=0x3FC -> stop, no wrap to 0.
//   - Stop/drain: run=0 with 2 buffered -> both delivered, then state=IDLE,
//     busy=0; run=1 resumes at next sequential pc.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: instr_mem port-B read path, PC redirect, and the
// valid/ready instruction handshake towards decode.
`timescale 1ns/1ps
interface instr_fetch_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;

    modport master (
        output mem_addr,
        input  mem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        input  mem_addr,
        output mem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: issues reads to a 1-cycle synchronous instr_mem, tags each
// with its PC and delivers {instr, instr_pc} to decode through a 2-entry buffer.
`timescale 1ns/1ps
module instr_fetch #(
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    instr_fetch_if.master     bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;

    logic [31:0] fetch_pc_p0;
    logic        vld_p1;
    logic [31:0] pc_p1;
    logic        vld_p2;
    logic [31:0] instr_p2;
    logic [31:0] pc_p2;
    logic        vld_p3;
    logic [31:0] instr_p3;
    logic [31:0] pc_p3;

    logic        xfer;
    logic [1:0]  occ;
    logic        below_limit;
    logic        room;
    logic        issue;
    logic        push;

    // occ counts both buffer slots plus the read still in flight, so a full
    // buffer can only accept a new issue when a transfer frees a slot now.
    assign xfer        = vld_p3 & bus.instr_ready;
    assign occ         = {1'b0, vld_p3} + {1'b0, vld_p2} + {1'b0, vld_p1};
    assign below_limit = fetch_pc_p0[31:2] < {{(30-ADDR_W-1){1'b0}}, word_count};
    assign room        = (occ < 2'd2) || ((occ == 2'd2) && xfer);
    assign issue       = (state == RUN) && !bus.redirect_valid && below_limit && room;
    assign push        = vld_p1 && !bus.redirect_valid;

    assign bus.mem_addr    = fetch_pc_p0[ADDR_W+1:2];
    assign bus.instr_valid = vld_p3;
    assign bus.instr       = instr_p3;
    assign bus.instr_pc    = pc_p3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!run) state <= DRAIN;
                end
                DRAIN: begin
                    if (run) begin
                        state <= RUN;
                    end else if (!vld_p1 && !vld_p2 && !vld_p3) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Stage p0 -> p1: issue; p1 -> p2/p3: return into skid slot / head slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_p0 <= RESET_PC;
            vld_p1      <= 1'b0;
            pc_p1       <= 32'h0;
            vld_p2      <= 1'b0;
            instr_p2    <= 32'h0;
            pc_p2       <= 32'h0;
            vld_p3      <= 1'b0;
            instr_p3    <= 32'h0;
            pc_p3       <= 32'h0;
        end else if (bus.redirect_valid) begin
            // Clearing vld_p1 drops the in-flight word when it returns next cycle.
            fetch_pc_p0 <= {bus.redirect_pc[31:2], 2'b00};
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            vld_p3      <= 1'b0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
                pc_p1       <= fetch_pc_p0;
            end

            if (!vld_p3 || xfer) begin
                if (vld_p2) begin
                    vld_p3   <= 1'b1;
                    instr_p3 <= instr_p2;
                    pc_p3    <= pc_p2;
                    vld_p2   <= push;
                    if (push) begin
                        instr_p2 <= bus.mem_rdata;
                        pc_p2    <= pc_p1;
                    end
                end else if (push) begin
                    vld_p3   <= 1'b1;
                    instr_p3 <= bus.mem_rdata;
                    pc_p3    <= pc_p1;
                end else begin
                    vld_p3 <= 1'b0;
                end
            end else if (push) begin
                vld_p2   <= 1'b1;
                instr_p2 <= bus.mem_rdata;
                pc_p2    <= pc_p1;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: cycle table for the first stream plus
// hand-written backpressure, reset, redirect, limit and drain sequences.
`timescale 1ns/1ps
module tb_instr_fetch;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [8:0]  word_count = 9'd0;
    logic        busy;

    instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .word_count (word_count),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr];

    int          n_cmp = 0;
    int          n_fail = 0;
    int          xfer_cnt = 0;
    logic [31:0] exp_next_pc = 32'h0;
    logic [31:0] last_pc = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_xfer(input int target, input int budget, input string name);
        int k = 0;
        while (xfer_cnt < target && k < budget) begin
            step();
            k++;
        end
        chk(name, 32'(xfer_cnt), 32'(target));
    endtask

    // Scoreboard on every delivered word: PCs must be sequential (except
    // after a redirect, when the bench reloads exp_next_pc) and data must match.
    always @(negedge clk) begin
        if (rst_n && bus.instr_valid && bus.instr_ready) begin
            chk("xfer_pc", bus.instr_pc, exp_next_pc);
            chk("xfer_instr", bus.instr, mem[bus.instr_pc[9:2]]);
            last_pc     = bus.instr_pc;
            exp_next_pc = bus.instr_pc + 32'd4;
            xfer_cnt++;
        end
    end

    typedef struct {
        logic        run;
        logic        ready;
        logic [8:0]  wc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_busy;
        logic [7:0]  e_addr;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        logic ok_a, ok_b, ok_c;

        for (int i = 0; i < 256; i++) mem[i] = 32'h13 + 32'(i) * 32'h100;
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        vecs[0] = '{1'b1, 1'b1, 9'd4, 1'b0, 32'h0, 32'h0,   1'b0, 8'd0};
        vecs[1] = '{1'b1, 1'b1, 9'd4, 1'b0, 32'h0, 32'h0,   1'b1, 8'd0};
        vecs[2] = '{1'b1, 1'b1, 9'd4, 1'b0, 32'h0, 32'h0,   1'b1, 8'd1};
        vecs[3] = '{1'b1, 1'b1, 9'd4, 1'b1, 32'h0, 32'h13,  1'b1, 8'd2};
        vecs[4] = '{1'b1, 1'b1, 9'd4, 1'b1, 32'h4, 32'h113, 1'b1, 8'd3};
        vecs[5] = '{1'b1, 1'b1, 9'd4, 1'b1, 32'h8, 32'h213, 1'b1, 8'd4};
        vecs[6] = '{1'b1, 1'b1, 9'd4, 1'b1, 32'hC, 32'h313, 1'b1, 8'd4};
        vecs[7] = '{1'b1, 1'b1, 9'd4, 1'b0, 32'hC, 32'h313, 1'b1, 8'd4};

        // Reset state
        step();
        step();
        @(negedge clk);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_instr", bus.instr, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Streaming table: one entry per cycle
        for (int i = 0; i < 8; i++) begin
            run             = vecs[i].run;
            bus.instr_ready = vecs[i].ready;
            word_count      = vecs[i].wc;
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_pc", i), bus.instr_pc, vecs[i].e_pc);
            chk($sformatf("v%0d_instr", i), bus.instr, vecs[i].e_instr);
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), 32'(vecs[i].e_addr));
            step();
        end

        // Backpressure: two words buffered and frozen, then released in order
        word_count      = 9'd8;
        bus.instr_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk("bp_valid", 32'(bus.instr_valid), 32'd1);
                chk("bp_pc", bus.instr_pc, 32'h10);
                chk("bp_instr", bus.instr, 32'h413);
            end
            step();
        end
        chk("bp_two_issued", 32'(bus.mem_addr), 32'd6);
        bus.instr_ready = 1'b1;
        wait_xfer(8, 30, "bp_count");
        chk("bp_last_pc", last_pc, 32'h1C);

        // Reset mid-stream with the buffer full
        word_count      = 9'd12;
        bus.instr_ready = 1'b0;
        for (int c = 0; c < 5; c++) step();
        chk("full_before_rst", 32'(bus.instr_valid), 32'd1);
        rst_n       = 1'b0;
        exp_next_pc = 32'h0;
        @(negedge clk);
        chk("mrst_valid", 32'(bus.instr_valid), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_addr", 32'(bus.mem_addr), 32'd0);
        step();
        rst_n = 1'b1;
        run   = 1'b0;
        bus.instr_ready = 1'b1;
        ok_a = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.instr_valid || busy || bus.mem_addr != 8'd0) ok_a = 1'b0;
            step();
        end
        chk("no_fetch_until_run", 32'(ok_a), 32'd1);

        // Redirect while pc 8 is in flight
        word_count = 9'd16;
        run        = 1'b1;
        step();
        step();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000000E;
        @(negedge clk);
        chk("redir_cycle_pc", bus.instr_pc, 32'h4);
        step();
        bus.redirect_valid = 1'b0;
        exp_next_pc        = 32'hC;
        base               = xfer_cnt;
        @(negedge clk);
        chk("redir_valid_drop", 32'(bus.instr_valid), 32'd0);
        chk("redir_fetch_addr", 32'(bus.mem_addr), 32'd3);
        step();
        wait_xfer(base + 1, 10, "redir_next_xfer");
        chk("redir_next_pc", last_pc, 32'hC);

        // Limit: stall at zero words, resume on growth, no wrap at full memory
        rst_n       = 1'b0;
        exp_next_pc = 32'h0;
        step();
        rst_n      = 1'b1;
        word_count = 9'd0;
        run        = 1'b1;
        base       = xfer_cnt;
        ok_b       = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.instr_valid || bus.mem_addr != 8'd0) ok_b = 1'b0;
            step();
        end
        chk("limit_zero_stall", 32'(ok_b), 32'd1);
        word_count = 9'd1;
        wait_xfer(base + 1, 10, "limit_grow_xfer");
        chk("limit_grow_pc", last_pc, 32'h0);
        word_count = 9'd256;
        wait_xfer(base + 256, 400, "full_mem_count");
        chk("full_mem_last_pc", last_pc, 32'h3FC);
        ok_c = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.instr_valid) ok_c = 1'b0;
            step();
        end
        chk("full_mem_no_wrap", 32'(ok_c), 32'd1);
        chk("full_mem_xfers", 32'(xfer_cnt), 32'(base + 256));
        chk("full_mem_busy", 32'(busy), 32'd1);

        // Stop/drain with two words buffered, then resume sequentially
        rst_n       = 1'b0;
        exp_next_pc = 32'h0;
        step();
        rst_n           = 1'b1;
        word_count      = 9'd8;
        run             = 1'b1;
        bus.instr_ready = 1'b0;
        for (int c = 0; c < 6; c++) step();
        chk("drain_two_issued", 32'(bus.mem_addr), 32'd2);
        run = 1'b0;
        step();
        base            = xfer_cnt;
        bus.instr_ready = 1'b1;
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd1);
        for (int c = 0; c < 6; c++) step();
        chk("drain_delivered", 32'(xfer_cnt), 32'(base + 2));
        chk("drain_idle_busy", 32'(busy), 32'd0);
        chk("drain_valid", 32'(bus.instr_valid), 32'd0);
        run = 1'b1;
        wait_xfer(base + 8, 30, "resume_count");
        chk("resume_last_pc", last_pc, 32'h1C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
